// File: rtl/register_file_wb_if.sv
// Decode/WriteBack bundle for the register file: Decode read ports, issue-side
// scoreboard set and WriteBack commit.
interface register_file_wb_if #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int AW    = $clog2(NREGS)
);
    logic [AW-1:0]    A1D;
    logic [AW-1:0]    A2D;
    logic [XLEN-1:0]  RD1D;
    logic [XLEN-1:0]  RD2D;
    logic             Busy1D;
    logic             Busy2D;
    logic             IssueD;
    logic             RegWriteD;
    logic [AW-1:0]    RdD;
    logic             RegWriteW;
    logic [AW-1:0]    RdW;
    logic [XLEN-1:0]  ResultW;
    logic [NREGS-1:0] PendingMask;

    modport master (
        output A1D, A2D, IssueD, RegWriteD, RdD, RegWriteW, RdW, ResultW,
        input  RD1D, RD2D, Busy1D, Busy2D, PendingMask
    );

    modport slave (
        input  A1D, A2D, IssueD, RegWriteD, RdD, RegWriteW, RdW, ResultW,
        output RD1D, RD2D, Busy1D, Busy2D, PendingMask
    );
endinterface

// File: rtl/register_file_wb.sv
// RISC-V integer register file with WriteBack commit, same-cycle read bypass
// and a pending-write scoreboard used by Decode for stall decisions.
module register_file_wb #(
    parameter int              XLEN      = 32,
    parameter int              NREGS     = 32,
    parameter logic [XLEN-1:0] SP_INIT   = 32'h0000_0FFC,
    parameter int              BYPASS_EN = 1
) (
    input logic               clk,
    input logic               rst,
    register_file_wb_if.slave bus
);
    localparam int AW = $clog2(NREGS);

    logic [XLEN-1:0]  r_regs [NREGS];
    logic [NREGS-1:0] r_pend;
    logic [NREGS-1:0] w_pend_next;
    logic             w_wr_en;
    logic             w_issue_wr;
    logic             w_byp1;
    logic             w_byp2;

    // Gating the commit with rst keeps reads showing reset contents while reset is held.
    assign w_wr_en    = rst && bus.RegWriteW && (bus.RdW != '0);
    assign w_issue_wr = bus.IssueD && bus.RegWriteD && (bus.RdD != '0);

    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_pend
            if (gi == 0) begin : g_zero
                assign w_pend_next[gi] = 1'b0;
            end else begin : g_bit
                // A new producer issuing on the same edge outranks the older commit.
                assign w_pend_next[gi] = (w_issue_wr && (bus.RdD == AW'(gi))) ||
                                         (r_pend[gi] && !(w_wr_en && (bus.RdW == AW'(gi))));
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= (i == 2) ? SP_INIT : '0;
            end
            r_pend <= '0;
        end else begin
            if (w_wr_en) begin
                r_regs[bus.RdW] <= bus.ResultW;
            end
            r_pend <= w_pend_next;
        end
    end

    assign w_byp1 = (BYPASS_EN != 0) && w_wr_en && (bus.RdW == bus.A1D);
    assign w_byp2 = (BYPASS_EN != 0) && w_wr_en && (bus.RdW == bus.A2D);

    assign bus.RD1D = (bus.A1D == '0) ? '0 : (w_byp1 ? bus.ResultW : r_regs[bus.A1D]);
    assign bus.RD2D = (bus.A2D == '0) ? '0 : (w_byp2 ? bus.ResultW : r_regs[bus.A2D]);

    // A register whose value is arriving through the bypass is already usable.
    assign bus.Busy1D = (bus.A1D != '0) && r_pend[bus.A1D] && !w_byp1;
    assign bus.Busy2D = (bus.A2D != '0) && r_pend[bus.A2D] && !w_byp2;

    assign bus.PendingMask = r_pend;
endmodule

// File: tb/tb_register_file_wb.sv
// Bench for register_file_wb: directed literal checks plus randomized traffic
// compared every cycle against an array-based model of the architectural state.
module tb_register_file_wb;
    localparam logic [31:0] SP = 32'h0000_0FFC;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic chk_en = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    register_file_wb_if bus ();

    register_file_wb dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Model: architectural registers and the set of registers awaiting a writer.
    logic [31:0] m_regs [32];
    logic [31:0] m_pend;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
            m_regs[2] = SP;
            m_pend    = 32'd0;
        end else begin
            if (bus.RegWriteW && bus.RdW != 5'd0) begin
                m_regs[bus.RdW] = bus.ResultW;
                m_pend[bus.RdW] = 1'b0;
            end
            if (bus.IssueD && bus.RegWriteD && bus.RdD != 5'd0)
                m_pend[bus.RdD] = 1'b1;
        end
    end

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (rst && bus.RegWriteW && bus.RdW == a) return bus.ResultW;
        return m_regs[a];
    endfunction

    function automatic logic [31:0] exp_busy(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (rst && bus.RegWriteW && bus.RdW == a) return 32'd0;
        return {31'd0, m_pend[a]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("rd1", bus.RD1D, exp_rd(bus.A1D));
            check("rd2", bus.RD2D, exp_rd(bus.A2D));
            check("busy1", {31'd0, bus.Busy1D}, exp_busy(bus.A1D));
            check("busy2", {31'd0, bus.Busy2D}, exp_busy(bus.A2D));
            check("pending", bus.PendingMask, m_pend);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.IssueD    = 1'b0;
        bus.RegWriteD = 1'b0;
        bus.RdD       = 5'd0;
        bus.RegWriteW = 1'b0;
        bus.RdW       = 5'd0;
        bus.ResultW   = 32'd0;
    endtask

    initial begin
        idle();
        bus.A1D = 5'd2;
        bus.A2D = 5'd5;
        #12;
        check("reset_rd1_sp", bus.RD1D, SP);
        check("reset_rd2", bus.RD2D, 32'd0);
        check("reset_mask", bus.PendingMask, 32'd0);
        check("reset_busy", {30'd0, bus.Busy1D, bus.Busy2D}, 32'd0);
        tick();
        rst    = 1'b1;
        chk_en = 1'b1;

        // Bypass on both ports, then stored value.
        bus.RegWriteW = 1'b1; bus.RdW = 5'd7; bus.ResultW = 32'hDEAD_BEEF;
        bus.A1D = 5'd7; bus.A2D = 5'd7;
        #1;
        check("bypass_rd1", bus.RD1D, 32'hDEAD_BEEF);
        check("bypass_rd2", bus.RD2D, 32'hDEAD_BEEF);
        tick();
        idle();
        #1;
        check("stored_rd1", bus.RD1D, 32'hDEAD_BEEF);
        check("stored_rd2", bus.RD2D, 32'hDEAD_BEEF);

        // x0 writes and issues are ignored.
        bus.RegWriteW = 1'b1; bus.RdW = 5'd0; bus.ResultW = 32'hFFFF_FFFF;
        bus.IssueD = 1'b1; bus.RegWriteD = 1'b1; bus.RdD = 5'd0;
        bus.A1D = 5'd0;
        #1;
        check("x0_before", bus.RD1D, 32'd0);
        tick();
        idle();
        #1;
        check("x0_after", bus.RD1D, 32'd0);
        check("x0_mask", bus.PendingMask, 32'd0);

        // Scoreboard set then clear through WriteBack.
        bus.IssueD = 1'b1; bus.RegWriteD = 1'b1; bus.RdD = 5'd9;
        tick();
        idle();
        bus.A1D = 5'd9;
        #1;
        check("sb_set_mask", bus.PendingMask, 32'h0000_0200);
        check("sb_busy", {31'd0, bus.Busy1D}, 32'd1);
        bus.RegWriteW = 1'b1; bus.RdW = 5'd9; bus.ResultW = 32'h0000_1234;
        #1;
        check("sb_wb_busy", {31'd0, bus.Busy1D}, 32'd0);
        check("sb_wb_rd", bus.RD1D, 32'h0000_1234);
        tick();
        idle();
        #1;
        check("sb_clear_mask", bus.PendingMask, 32'd0);

        // Set wins over a simultaneous clear.
        bus.IssueD = 1'b1; bus.RegWriteD = 1'b1; bus.RdD = 5'd12;
        bus.RegWriteW = 1'b1; bus.RdW = 5'd12; bus.ResultW = 32'hCAFE_0012;
        tick();
        idle();
        bus.A1D = 5'd12;
        #1;
        check("setwins_mask", bus.PendingMask, 32'h0000_1000);
        check("setwins_rd", bus.RD1D, 32'hCAFE_0012);
        check("setwins_busy", {31'd0, bus.Busy1D}, 32'd1);

        // Asynchronous reset mid-cycle discards the pending write.
        bus.RegWriteW = 1'b1; bus.RdW = 5'd5; bus.ResultW = 32'hA5A5_A5A5;
        tick();
        idle();
        bus.A1D = 5'd5;
        #1;
        check("x5_written", bus.RD1D, 32'hA5A5_A5A5);
        tick();
        bus.RegWriteW = 1'b1; bus.RdW = 5'd6; bus.ResultW = 32'h0000_0077;
        bus.A2D = 5'd6;
        #1;
        rst = 1'b0;
        #1;
        check("async_x5", bus.RD1D, 32'd0);
        check("async_mask", bus.PendingMask, 32'd0);
        check("async_x6_rd", bus.RD2D, 32'd0);
        tick();
        idle();
        rst = 1'b1;
        bus.A1D = 5'd2;
        #1;
        check("post_reset_x6", bus.RD2D, 32'd0);
        check("post_reset_sp", bus.RD1D, SP);

        // Randomized traffic on a narrow address range to force collisions.
        for (int c = 0; c < 400; c++) begin
            tick();
            rst           = 1'b1;
            bus.A1D       = 5'($urandom_range(0, 15));
            bus.A2D       = 5'($urandom_range(0, 15));
            bus.RegWriteW = 1'($urandom_range(0, 1));
            bus.RdW       = ($urandom_range(0, 3) == 0) ? bus.A1D : 5'($urandom_range(0, 15));
            bus.ResultW   = $urandom;
            bus.IssueD    = 1'($urandom_range(0, 1));
            bus.RegWriteD = ($urandom_range(0, 3) != 0);
            bus.RdD       = ($urandom_range(0, 4) == 0) ? bus.RdW : 5'($urandom_range(0, 15));
            if ($urandom_range(0, 63) == 0) begin
                #2;
                rst = 1'b0;
            end
        end
        tick();
        rst = 1'b1;
        idle();
        tick();
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
